// File: rtl/adder_subtractor_arbiter_pkg.sv
// Shared widths and FSM encoding for the arbitrated adder/subtractor.
package adder_subtractor_arbiter_pkg;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_subtractor_arbiter_if.sv
// Two-port request/grant/done bus between operand sources and the shared arithmetic unit.
interface adder_subtractor_arbiter_if;
    import adder_subtractor_arbiter_pkg::*;

    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             sub0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             sub1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    modport master (
        output req0, a0, b0, sub0, req1, a1, b1, sub1,
        input  gnt0, gnt1, done0, done1, result, busy, op_count
    );

    modport slave (
        input  req0, a0, b0, sub0, req1, a1, b1, sub1,
        output gnt0, gnt1, done0, done1, result, busy, op_count
    );

endinterface

// File: rtl/adder_subtractor_arbiter_alu.sv
// Shared combinational adder/subtractor: button=0 adds, button=1 subtracts (modulo 2^WIDTH).
module adder_subtractor
    import adder_subtractor_arbiter_pkg::*;
(
    output logic [WIDTH-1:0] R,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             button
);

    assign R = button ? (A - B) : (A + B);

endmodule

// File: rtl/adder_subtractor_arbiter.sv
// Round-robin arbiter sharing one adder_subtractor between two requesters,
// with registered result, done pulses and a completed-operation counter.
//
// state  | meaning
// S_IDLE | waiting for a request; arbitration and operand capture happen here
// S_EXEC | captured operands drive the datapath; grant pulse is high
// S_DONE | result registered; done pulse is high
module adder_subtractor_arbiter
    import adder_subtractor_arbiter_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    adder_subtractor_arbiter_if.slave   bus
);

    state_t           state;
    state_t           state_next;
    logic             last_id;
    logic             grant_id;
    logic             win_id;
    logic             any_req;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sub;
    logic [WIDTH-1:0] alu_r;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] op_count;

    adder_subtractor u_alu (
        .R      (alu_r),
        .A      (op_a),
        .B      (op_b),
        .button (op_sub)
    );

    always_comb begin
        any_req    = bus.req0 | bus.req1;
        win_id     = bus.req1;
        state_next = state;
        // Under contention the port that did not win last time goes next.
        if (bus.req0 && bus.req1) begin
            win_id = ~last_id;
        end
        case (state)
            S_IDLE:  if (any_req) state_next = S_EXEC;
            S_EXEC:  state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            last_id  <= 1'b1;
            grant_id <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_sub   <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            result   <= '0;
            op_count <= '0;
        end else begin
            state <= state_next;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        op_a     <= win_id ? bus.a1   : bus.a0;
                        op_b     <= win_id ? bus.b1   : bus.b0;
                        op_sub   <= win_id ? bus.sub1 : bus.sub0;
                        grant_id <= win_id;
                        last_id  <= win_id;
                        gnt0     <= ~win_id;
                        gnt1     <= win_id;
                    end
                end
                S_EXEC: begin
                    result   <= alu_r;
                    done0    <= ~grant_id;
                    done1    <= grant_id;
                    op_count <= op_count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt0     = gnt0;
    assign bus.gnt1     = gnt1;
    assign bus.done0    = done0;
    assign bus.done1    = done1;
    assign bus.result   = result;
    assign bus.op_count = op_count;
    assign bus.busy     = (state != S_IDLE);

endmodule

// File: tb/tb_adder_subtractor_arbiter.sv
// Scoreboard bench: expected {port, result} entries are queued at drive time and
// retired against each done pulse; handshake timing and reset behaviour checked directly.
module tb_adder_subtractor_arbiter;
    import adder_subtractor_arbiter_pkg::*;

    typedef struct packed {
        logic             port;
        logic [WIDTH-1:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    adder_subtractor_arbiter_if bus();

    adder_subtractor_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t             sb[$];
    int               checks    = 0;
    int               failures  = 0;
    logic [CNT_W-1:0] exp_count = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] calc(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic sub);
        int r;
        r = sub ? (int'(a) - int'(b)) : (int'(a) + int'(b));
        return WIDTH'(r & ((1 << WIDTH) - 1));
    endfunction

    // One cycle: sample at the falling edge and retire any completion against the scoreboard.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (reset) begin
            sb.delete();
            exp_count = '0;
        end else begin
            if (bus.gnt0 || bus.gnt1)
                check("gnt_onehot", 32'(bus.gnt0 & bus.gnt1), 32'd0);
            if (bus.done0 || bus.done1) begin
                check("done_onehot", 32'(bus.done0 & bus.done1), 32'd0);
                if (sb.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    exp_count++;
                    check("done_port", 32'(bus.done1), 32'(e.port));
                    check("result", 32'(bus.result), 32'(e.res));
                    check("op_count", 32'(bus.op_count), 32'(exp_count));
                end
            end
        end
    endtask

    task automatic drive(input logic port, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sub);
        exp_t e;
        if (!port) begin
            bus.a0 = a; bus.b0 = b; bus.sub0 = sub; bus.req0 = 1'b1;
        end else begin
            bus.a1 = a; bus.b1 = b; bus.sub1 = sub; bus.req1 = 1'b1;
        end
        e.port = port;
        e.res  = calc(a, b, sub);
        sb.push_back(e);
    endtask

    task automatic wait_gnt(input logic exp_port, input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(bus.gnt0 || bus.gnt1) && n < 8);
        if (!(bus.gnt0 || bus.gnt1)) check({tag, "_timeout"}, 32'd1, 32'd0);
        else                         check(tag, 32'(bus.gnt1), 32'(exp_port));
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(bus.done0 || bus.done1) && n < 8);
        if (!(bus.done0 || bus.done1)) check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic run_op(input logic port, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sub);
        drive(port, a, b, sub);
        wait_gnt(port, "op_gnt");
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        wait_done("op_done");
        tick();
    endtask

    task automatic apply_reset();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0; bus.sub0 = 1'b0;
        bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0; bus.sub1 = 1'b0;

        // Reset held two cycles, then idle.
        apply_reset();
        tick();
        check("rst_gnt0",  32'(bus.gnt0),     32'd0);
        check("rst_gnt1",  32'(bus.gnt1),     32'd0);
        check("rst_done0", 32'(bus.done0),    32'd0);
        check("rst_done1", 32'(bus.done1),    32'd0);
        check("rst_busy",  32'(bus.busy),     32'd0);
        check("rst_result", 32'(bus.result),  32'd0);
        check("rst_count", 32'(bus.op_count), 32'd0);

        // Exact latency of a single port-0 add: 10 + 15 wraps to 9.
        drive(1'b0, 4'd10, 4'd15, 1'b0);
        tick();
        check("lat_gnt0", 32'(bus.gnt0), 32'd1);
        check("lat_gnt1", 32'(bus.gnt1), 32'd0);
        check("lat_busy_exec", 32'(bus.busy), 32'd1);
        bus.req0 = 1'b0;
        tick();
        check("lat_done0", 32'(bus.done0), 32'd1);
        check("lat_result", 32'(bus.result), 32'd9);
        check("lat_count", 32'(bus.op_count), 32'd1);
        tick();
        check("lat_busy_idle", 32'(bus.busy), 32'd0);
        check("lat_done_clear", 32'(bus.done0), 32'd0);

        // Port-1 subtraction wraps two's complement; result holds after done.
        run_op(1'b1, 4'd1, 4'd4, 1'b1);
        check("sub_wrap_hold", 32'(bus.result), 32'hD);
        run_op(1'b1, 4'd10, 4'd15, 1'b1);
        check("sub_wrap2_hold", 32'(bus.result), 32'hB);

        // Both ports held from reset: grants alternate 0,1,0,1; operand changes
        // after a grant only affect that port's next operation.
        apply_reset();
        drive(1'b0, 4'd3, 4'd5, 1'b0);
        drive(1'b1, 4'd7, 4'd9, 1'b1);
        wait_gnt(1'b0, "rr_gnt_a");
        drive(1'b0, 4'd12, 4'd6, 1'b1);
        wait_gnt(1'b1, "rr_gnt_b");
        drive(1'b1, 4'd15, 4'd1, 1'b0);
        wait_gnt(1'b0, "rr_gnt_c");
        wait_gnt(1'b1, "rr_gnt_d");
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        wait_done("rr_done");
        tick();
        check("rr_sb_empty", 32'(sb.size()), 32'd0);
        check("rr_count", 32'(bus.op_count), 32'd4);

        // Reset during EXEC of a port-0 op aborts it and restores port-0 priority.
        bus.a0 = 4'd2; bus.b0 = 4'd3; bus.sub0 = 1'b0; bus.req0 = 1'b1;
        tick();
        check("abort_in_exec", 32'(bus.gnt0), 32'd1);
        reset = 1'b1;
        bus.req0 = 1'b0;
        tick();
        check("abort_done0", 32'(bus.done0), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_count", 32'(bus.op_count), 32'd0);
        reset = 1'b0;
        tick();
        check("abort_no_done", 32'(bus.done0 | bus.done1), 32'd0);
        drive(1'b0, 4'd6, 4'd9, 1'b0);
        bus.a1 = 4'd1; bus.b1 = 4'd1; bus.sub1 = 1'b0; bus.req1 = 1'b1;
        wait_gnt(1'b0, "abort_next_gnt");
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        wait_done("abort_next_done");
        tick();

        // 256 back-to-back port-0 ops: counter wraps to zero.
        apply_reset();
        drive(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 256; i++) begin
            wait_gnt(1'b0, "b2b_gnt");
            if (i < 255)
                drive(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)));
            else
                bus.req0 = 1'b0;
        end
        wait_done("b2b_done");
        tick();
        check("b2b_count_wrap", 32'(bus.op_count), 32'd0);
        check("b2b_sb_empty", 32'(sb.size()), 32'd0);
        check("b2b_busy", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
